dsp48a1_core: RTL and testbench
===============================

// Module: dsp48a1_core
// PURPOSE
//  Behavioural DSP48A1-style multiply/accumulate slice. It consumes the 92-bit
//  dsp_ins_flat bundle {opmode,a,b,c} that the ALU blocks (alu_filter_iir etc.)
//  drive, and returns the 48-bit P register as dsp_outs_flat.
//  Used for simulation and as the portable fallback where no DSP48A1 primitive exists.
// PARAMETERS
//  AREG  1  input stage register on opmode/a/b/c (0 = combinational input)
//  MREG  1  multiplier output register, opmode/c delayed alongside (0 = none)
//  (PREG fixed at 1; total latency L = AREG + MREG + 1 cycles)
// PORTS
//  clk            in   1   system clock, all regs on posedge
//  reset          in   1   synchronous, active-high; clears every register
//  dsp_ins_flat   in   92  {opmode[91:84], a[83:66], b[65:48], c[47:0]}; a,b,c signed
//  dsp_outs_flat  out  48  P register, signed
// BEHAVIOUR
//  - Reset: one clk edge with reset=1 zeroes the input stage, M stage, opmode
//    pipe and P, so dsp_outs_flat=48'h0 the cycle after; bubbles in flight become NOP.
//  - Opmode fields (DSP48A1 layout):
//    [1:0] X: 0=zero, 1=M, 2=P, 3={12'h000,a,b}
//    [3:2] Z: 0=zero, 1=PCIN (tied 0), 2=P, 3=c
//    [4] pre-adder enable, [6] pre-add subtract. No D port (D=0):
//        b'=([4]&[6]) ? -b : b
//    [5] carry-in bit; [7] post subtract.
//  - P_next = [7] ? Z - (X + cin) : Z + X + cin, mod 2^48 (wraps, no saturation).
//  - M = a*b'. Full signed 36-bit product, sign-extended to 48.
//    -2^17 * -2^17 = +2^34 is exact.
//  - NOP: opmode==8'h00 (DSP_NOP) holds P unchanged. This is the one deliberate
//    departure from silicon, where X=Z=0 would clear P. Clear P with X=1 and a=0.
//  - Opmode, c and the product/operands advance one stage per cycle together.
//    The op issued at cycle n is reflected in P at edge n+L.
//  - Feedback (X=2 or Z=2) reads P as it is at the post-adder stage.
//    So back-to-back ops with Z=P accumulate in issue order with no stall.
//    Example: MUL then 3x MAC gives P = sum of the 4 products at edge n+3+L.
//  - No handshake. A new op is accepted every cycle and nothing is ever dropped.
//  - Reset mid-accumulation discards all in-flight ops; the first post-reset op
//    sees P=0.
//  - P pipeline ops whose result P is never consumed are legal. There is no
//    overflow flag.
// STRUCTURE
//  - Opmode field positions, widths and the DSP_* macros (DSP_NOP, DSP_XIN_MULT,
//    DSP_ZIN_ZERO, DSP_ZIN_POUT, ...) live in globals.vh; the packing offsets are
//    added there as DSP_IN_OPMODE_LSB etc.
//  - One sub-module, dsp48a1_postadd: a combinational X/Z mux plus the 48-bit
//    add/sub with carry-in. The core keeps the input, M and P registers.
//  - The AREG/MREG=0 variants are generate-if bypasses, not separate modules.
// TESTING (run for AREG/MREG = 1/1 and 0/0)
//  1 Reset: drive ops, assert reset 1 cycle -> P=0 next cycle.
//    NOPs afterwards -> P stays 0.
//  2 MUL: opmode=X=M,Z=0, a=18'h0009b, b=18'h10000 -> after L cycles
//    P=48'h0000_009b_0000.
//  3 MAC chain: MUL a=2,b=3 then MAC(Z=P) a=4,b=5; a=-1,b=7; a=10,b=-10
//    -> P=6,26,19,-81, one per cycle starting at L.
//  4 Extremes: a=b=18'h20000 -> P=48'h0004_0000_0000.
//    MAC a=18'h1ffff,b=18'h1ffff -> P=2^34+(2^17-1)^2.
//  5 NOP hold: P=1234, then 5 NOPs -> P stays 1234.
//    X=1 with a=0, Z=0 -> P=0 next L.
//  6 Post-sub/C path: c=100, Z=C, X=M, [7]=1, a=3,b=4 -> P=88.
//    Same with [5]=1 -> 87. P=48'h7fff_ffff_ffff plus 1 -> 48'h8000_0000_0000.

Source files
------------

// File: rtl/dsp48a1_core_pkg.sv
// Shared types for the DSP48A1-style MAC slice: input bundle layout,
// post-adder mux selects and opmode bit positions.
package dsp48a1_core_pkg;

  localparam int DSP_OPMODE_W = 8;
  localparam int DSP_AB_W     = 18;
  localparam int DSP_P_W      = 48;
  localparam int DSP_IN_W     = DSP_OPMODE_W + 2 * DSP_AB_W + DSP_P_W;

  localparam logic [DSP_OPMODE_W-1:0] DSP_NOP = 8'h00;

  localparam int OP_PREADD_EN = 4;
  localparam int OP_CIN       = 5;
  localparam int OP_PRESUB    = 6;
  localparam int OP_POSTSUB   = 7;

  typedef enum logic [1:0] {
    XIN_ZERO = 2'd0,
    XIN_MULT = 2'd1,
    XIN_POUT = 2'd2,
    XIN_AB   = 2'd3
  } xin_e;

  typedef enum logic [1:0] {
    ZIN_ZERO = 2'd0,
    ZIN_PCIN = 2'd1,
    ZIN_POUT = 2'd2,
    ZIN_C    = 2'd3
  } zin_e;

  // Field order matches the flat bus {opmode, a, b, c}, MSB first.
  typedef struct packed {
    logic [DSP_OPMODE_W-1:0] opmode;
    logic [DSP_AB_W-1:0]     a;
    logic [DSP_AB_W-1:0]     b;
    logic [DSP_P_W-1:0]      c;
  } dsp_in_t;

  typedef struct packed {
    logic [DSP_OPMODE_W-1:0] opmode;
    logic [2*DSP_AB_W-1:0]   ab;
    logic [DSP_P_W-1:0]      m;
    logic [DSP_P_W-1:0]      c;
  } m_stage_t;

endpackage

// File: rtl/dsp48a1_postadd.sv
// Post-adder: X/Z operand muxes and 48-bit add/subtract with carry-in.
module dsp48a1_postadd
  import dsp48a1_core_pkg::*;
(
  input  logic [1:0]            x_sel,
  input  logic [1:0]            z_sel,
  input  logic                  cin,
  input  logic                  post_sub,
  input  logic [2*DSP_AB_W-1:0] ab,
  input  logic [DSP_P_W-1:0]    m,
  input  logic [DSP_P_W-1:0]    c,
  input  logic [DSP_P_W-1:0]    p,
  output logic [DSP_P_W-1:0]    p_next
);

  logic [DSP_P_W-1:0] x_mux;
  logic [DSP_P_W-1:0] z_mux;
  logic [DSP_P_W-1:0] cin_ext;

  always_comb begin
    x_mux = '0;
    case (xin_e'(x_sel))
      XIN_ZERO: x_mux = '0;
      XIN_MULT: x_mux = m;
      XIN_POUT: x_mux = p;
      XIN_AB:   x_mux = {{(DSP_P_W-2*DSP_AB_W){1'b0}}, ab};
      default:  x_mux = '0;
    endcase

    // There is no cascade input, so PCIN reads as zero.
    z_mux = '0;
    case (zin_e'(z_sel))
      ZIN_ZERO: z_mux = '0;
      ZIN_PCIN: z_mux = '0;
      ZIN_POUT: z_mux = p;
      ZIN_C:    z_mux = c;
      default:  z_mux = '0;
    endcase

    cin_ext = {{(DSP_P_W-1){1'b0}}, cin};
    if (post_sub) p_next = z_mux - (x_mux + cin_ext);
    else          p_next = z_mux + x_mux + cin_ext;
  end

endmodule

// File: rtl/dsp48a1_core.sv
// Behavioural DSP48A1-style multiply/accumulate slice with optional input
// and multiplier pipeline registers; P is always registered.
module dsp48a1_core
  import dsp48a1_core_pkg::*;
#(
  parameter int AREG = 1,
  parameter int MREG = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DSP_IN_W-1:0] dsp_ins_flat,
  output logic [DSP_P_W-1:0]  dsp_outs_flat
);

  dsp_in_t  in_raw;
  dsp_in_t  in_s;
  m_stage_t m_in;
  m_stage_t m_s;

  assign in_raw = dsp_in_t'(dsp_ins_flat);

  generate
    if (AREG != 0) begin : g_areg
      dsp_in_t in_d;
      dsp_in_t in_q;
      always_comb in_d = in_raw;
      always_ff @(posedge clk) begin
        if (reset) in_q <= '0;
        else       in_q <= in_d;
      end
      assign in_s = in_q;
    end else begin : g_areg_bypass
      assign in_s = in_raw;
    end
  endgenerate

  // b is widened by one bit so negating -2^17 stays exact.
  logic               pre_sub;
  logic signed [18:0] b_pre;
  logic signed [36:0] prod;

  always_comb begin
    pre_sub = in_s.opmode[OP_PREADD_EN] & in_s.opmode[OP_PRESUB];
    b_pre   = {in_s.b[DSP_AB_W-1], in_s.b};
    if (pre_sub) b_pre = -b_pre;
    prod = $signed(in_s.a) * b_pre;

    m_in.opmode = in_s.opmode;
    m_in.ab     = {in_s.a, in_s.b};
    m_in.m      = {{(DSP_P_W-37){prod[36]}}, prod};
    m_in.c      = in_s.c;
  end

  generate
    if (MREG != 0) begin : g_mreg
      m_stage_t m_d;
      m_stage_t m_q;
      always_comb m_d = m_in;
      always_ff @(posedge clk) begin
        if (reset) m_q <= '0;
        else       m_q <= m_d;
      end
      assign m_s = m_q;
    end else begin : g_mreg_bypass
      assign m_s = m_in;
    end
  endgenerate

  logic [DSP_P_W-1:0] p_next;
  logic [DSP_P_W-1:0] p_d;
  logic [DSP_P_W-1:0] p_q;

  dsp48a1_postadd u_postadd (
    .x_sel    (m_s.opmode[1:0]),
    .z_sel    (m_s.opmode[3:2]),
    .cin      (m_s.opmode[OP_CIN]),
    .post_sub (m_s.opmode[OP_POSTSUB]),
    .ab       (m_s.ab),
    .m        (m_s.m),
    .c        (m_s.c),
    .p        (p_q),
    .p_next   (p_next)
  );

  // An all-zero opmode holds P instead of clearing it, unlike silicon.
  always_comb begin
    p_d = p_q;
    if (m_s.opmode != DSP_NOP) p_d = p_next;
  end

  always_ff @(posedge clk) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign dsp_outs_flat = p_q;

endmodule

// File: tb/tb_dsp48a1_core.sv
// Checks the 1/1 (L=3) and 0/0 (L=1) variants side by side against an
// issue-order arithmetic model of P.
module tb_dsp48a1_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [91:0] dsp_ins_flat = '0;
  logic [47:0] p3;
  logic [47:0] p1;

  int vectors = 0;
  int miscompares = 0;

  logic [47:0] model_p = '0;
  logic [47:0] q3[$];
  logic [47:0] q1[$];

  dsp48a1_core #(.AREG(1), .MREG(1)) u_dut_l3 (
    .clk(clk), .reset(reset), .dsp_ins_flat(dsp_ins_flat), .dsp_outs_flat(p3));
  dsp48a1_core #(.AREG(0), .MREG(0)) u_dut_l1 (
    .clk(clk), .reset(reset), .dsp_ins_flat(dsp_ins_flat), .dsp_outs_flat(p1));

  always #5 clk = ~clk;

  // P after applying one op to the previous P, straight from the opmode rules.
  function automatic logic [47:0] ref_op(input logic [47:0] p, input logic [7:0] op,
                                         input logic [17:0] a, input logic [17:0] b,
                                         input logic [47:0] c);
    longint av, bv, x, z, r;
    if (op == 8'h00) return p;
    av = longint'($signed(a));
    bv = longint'($signed(b));
    if (op[4] && op[6]) bv = -bv;
    case (op[1:0])
      2'd0:    x = 0;
      2'd1:    x = av * bv;
      2'd2:    x = longint'(p);
      default: x = longint'({a, b});
    endcase
    case (op[3:2])
      2'd2:    z = longint'(p);
      2'd3:    z = longint'(c);
      default: z = 0;
    endcase
    if (op[7]) r = z - (x + longint'(op[5]));
    else       r = z + x + longint'(op[5]);
    return r[47:0];
  endfunction

  // Drives one op for one cycle and returns what each variant should show
  // just after the edge: the L=3 slice lags the model by two ops.
  task automatic step(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                      input logic [47:0] c, input logic rst,
                      output logic [47:0] e3, output logic [47:0] e1);
    dsp_ins_flat = {op, a, b, c};
    reset = rst;
    if (!rst) begin
      model_p = ref_op(model_p, op, a, b, c);
      q3.push_back(model_p);
      q1.push_back(model_p);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_p = '0;
      q3.delete();
      q1.delete();
      q3.push_back('0);
      q3.push_back('0);
      e3 = '0;
      e1 = '0;
    end else begin
      e3 = q3.pop_front();
      e1 = q1.pop_front();
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] e3, e1;
    step(8'h00, 18'h0, 18'h0, 48'h0, 1'b1, e3, e1);
    vectors += 2;
    if (p3 !== 48'h0) begin miscompares++; $display("FAIL reset_init_l3 got %h exp 0", p3); end
    if (p1 !== 48'h0) begin miscompares++; $display("FAIL reset_init_l1 got %h exp 0", p1); end
    for (int i = 0; i < 4; i++)
      step(8'h09, 18'($urandom()), 18'($urandom()), 48'h0, 1'b0, e3, e1);
    step(8'h09, 18'h5, 18'h5, 48'h0, 1'b1, e3, e1);
    vectors += 2;
    if (p3 !== 48'h0) begin miscompares++; $display("FAIL reset_busy_l3 got %h exp 0", p3); end
    if (p1 !== 48'h0) begin miscompares++; $display("FAIL reset_busy_l1 got %h exp 0", p1); end
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 18'($urandom()), 18'($urandom()), 48'h0, 1'b0, e3, e1);
      vectors += 2;
      if (p3 !== 48'h0) begin miscompares++; $display("FAIL reset_nop_l3 i=%0d got %h exp 0", i, p3); end
      if (p1 !== 48'h0) begin miscompares++; $display("FAIL reset_nop_l1 i=%0d got %h exp 0", i, p1); end
    end
  endtask

  task automatic test_mul();
    logic [47:0] e3, e1;
    step(8'h01, 18'h0009b, 18'h10000, 48'h0, 1'b0, e3, e1);
    for (int i = 0; i < 3; i++) step(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, e3, e1);
    vectors += 2;
    if (p3 !== 48'h0000_009b_0000) begin miscompares++; $display("FAIL mul_l3 got %h exp 00000009b0000", p3); end
    if (p1 !== 48'h0000_009b_0000) begin miscompares++; $display("FAIL mul_l1 got %h exp 00000009b0000", p1); end
  endtask

  task automatic test_mac_chain();
    logic [47:0] e3, e1;
    logic [7:0]  ops[4]   = '{8'h01, 8'h09, 8'h09, 8'h09};
    logic [17:0] as[4]    = '{18'd2, 18'd4, 18'h3ffff, 18'd10};
    logic [17:0] bs[4]    = '{18'd3, 18'd5, 18'd7, 18'h3fff6};
    logic [47:0] exp_p[4] = '{48'd6, 48'd26, 48'd19, 48'hffff_ffff_ffaf};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(ops[i], as[i], bs[i], 48'h0, 1'b0, e3, e1);
      else       step(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, e3, e1);
      if (i < 4) begin
        vectors++;
        if (p1 !== exp_p[i]) begin miscompares++; $display("FAIL mac_chain_l1 i=%0d got %h exp %h", i, p1, exp_p[i]); end
      end
      if (i >= 2) begin
        vectors++;
        if (p3 !== exp_p[i-2]) begin miscompares++; $display("FAIL mac_chain_l3 i=%0d got %h exp %h", i, p3, exp_p[i-2]); end
      end
    end
  endtask

  task automatic test_extremes();
    logic [47:0] e3, e1;
    step(8'h01, 18'h20000, 18'h20000, 48'h0, 1'b0, e3, e1);
    for (int i = 0; i < 2; i++) step(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, e3, e1);
    vectors += 2;
    if (p3 !== 48'h0004_0000_0000) begin miscompares++; $display("FAIL ext_min_l3 got %h exp 000400000000", p3); end
    if (p1 !== 48'h0004_0000_0000) begin miscompares++; $display("FAIL ext_min_l1 got %h exp 000400000000", p1); end
    step(8'h09, 18'h1ffff, 18'h1ffff, 48'h0, 1'b0, e3, e1);
    for (int i = 0; i < 2; i++) step(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, e3, e1);
    vectors += 2;
    if (p3 !== 48'h0007_fffc_0001) begin miscompares++; $display("FAIL ext_max_l3 got %h exp 0007fffc0001", p3); end
    if (p1 !== 48'h0007_fffc_0001) begin miscompares++; $display("FAIL ext_max_l1 got %h exp 0007fffc0001", p1); end
  endtask

  task automatic test_nop_hold();
    logic [47:0] e3, e1;
    step(8'h0c, 18'h0, 18'h0, 48'd1234, 1'b0, e3, e1);
    for (int i = 0; i < 2; i++) step(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, e3, e1);
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 18'($urandom()), 18'($urandom()), 48'($urandom()), 1'b0, e3, e1);
      vectors += 2;
      if (p3 !== 48'd1234) begin miscompares++; $display("FAIL nop_hold_l3 i=%0d got %0d exp 1234", i, p3); end
      if (p1 !== 48'd1234) begin miscompares++; $display("FAIL nop_hold_l1 i=%0d got %0d exp 1234", i, p1); end
    end
    step(8'h01, 18'h0, 18'($urandom()), 48'h0, 1'b0, e3, e1);
    for (int i = 0; i < 2; i++) step(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, e3, e1);
    vectors += 2;
    if (p3 !== 48'h0) begin miscompares++; $display("FAIL nop_clear_l3 got %h exp 0", p3); end
    if (p1 !== 48'h0) begin miscompares++; $display("FAIL nop_clear_l1 got %h exp 0", p1); end
  endtask

  task automatic test_postsub();
    logic [47:0] e3, e1;
    logic [7:0]  ops[4]   = '{8'h8d, 8'had, 8'h51, 8'h0c};
    logic [47:0] cs[4]    = '{48'd100, 48'd100, 48'd0, 48'h7fff_ffff_ffff};
    logic [47:0] exp_p[4] = '{48'd88, 48'd87, 48'hffff_ffff_fff4, 48'h8000_0000_0000};
    for (int k = 0; k < 4; k++) begin
      step(ops[k], 18'd3, 18'd4, cs[k], 1'b0, e3, e1);
      if (k == 3) step(8'h28, 18'd0, 18'd0, 48'h0, 1'b0, e3, e1);
      for (int i = 0; i < 2; i++) step(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, e3, e1);
      vectors += 2;
      if (p3 !== exp_p[k]) begin miscompares++; $display("FAIL postsub_l3 k=%0d got %h exp %h", k, p3, exp_p[k]); end
      if (p1 !== exp_p[k]) begin miscompares++; $display("FAIL postsub_l1 k=%0d got %h exp %h", k, p1, exp_p[k]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [47:0] e3, e1;
    for (int i = 0; i < 3; i++)
      step(8'h09, 18'($urandom()), 18'($urandom()), 48'h0, 1'b0, e3, e1);
    step(8'h09, 18'd7, 18'd7, 48'h0, 1'b1, e3, e1);
    step(8'h09, 18'd2, 18'd3, 48'h0, 1'b0, e3, e1);
    for (int i = 0; i < 2; i++) step(8'h00, 18'h0, 18'h0, 48'h0, 1'b0, e3, e1);
    vectors += 2;
    if (p3 !== 48'd6) begin miscompares++; $display("FAIL reset_mid_l3 got %h exp 6", p3); end
    if (p1 !== 48'd6) begin miscompares++; $display("FAIL reset_mid_l1 got %h exp 6", p1); end
  endtask

  task automatic test_random();
    logic [47:0] e3, e1;
    logic [7:0]  op;
    logic [17:0] a, b;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom());
      case ($urandom_range(3))
        0:       begin a = 18'h20000; b = 18'($urandom()); end
        1:       begin a = 18'($urandom()); b = 18'h1ffff; end
        default: begin a = 18'($urandom()); b = 18'($urandom()); end
      endcase
      step(op, a, b, 48'({$urandom(), $urandom()}), 1'b0, e3, e1);
      vectors += 2;
      if (p3 !== e3) begin miscompares++; $display("FAIL random_l3 i=%0d op=%h got %h exp %h", i, op, p3, e3); end
      if (p1 !== e1) begin miscompares++; $display("FAIL random_l1 i=%0d op=%h got %h exp %h", i, op, p1, e1); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mul();
    test_mac_chain();
    test_extremes();
    test_nop_hold();
    test_postsub();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
